// File: rtl/esp_at_pkg.sv
// ============================================================================
//  Module      : esp_at_pkg
//  Description : Shared types and constants for the ESP8266 AT line parser:
//                line kind codes, control characters and result keywords.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package esp_at_pkg;

    // Line classification reported on line_kind
    typedef enum logic [2:0] {
        KIND_OTHER = 3'd0,
        KIND_OK    = 3'd1,
        KIND_ERROR = 3'd2,
        KIND_READY = 3'd3,
        KIND_FAIL  = 3'd4
    } line_kind_e;

    // Parser states: assembling a line, or holding a finished one
    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    localparam logic [7:0] CHAR_CR     = 8'h0D;
    localparam logic [7:0] CHAR_LF     = 8'h0A;
    localparam logic [7:0] CHAR_PROMPT = 8'h3E;

    // Keywords are right-justified in a 40-bit field; first character is the
    // most significant populated byte.
    localparam logic [39:0] KW_OK_STR    = 40'("OK");
    localparam logic [39:0] KW_ERROR_STR = 40'("ERROR");
    localparam logic [39:0] KW_READY_STR = 40'("ready");
    localparam logic [39:0] KW_FAIL_STR  = 40'("FAIL");
    localparam int KW_OK_LEN    = 2;
    localparam int KW_ERROR_LEN = 5;
    localparam int KW_READY_LEN = 5;
    localparam int KW_FAIL_LEN  = 4;

    // True when character ch equals keyword character at position pos
    function automatic logic kw_hit(input logic [39:0] str, input int len,
                                    input int pos, input logic [7:0] ch);
        if (pos >= len) begin
            return 1'b0;
        end
        return str[(len - 1 - pos) * 8 +: 8] == ch;
    endfunction

endpackage

`default_nettype wire

// File: rtl/esp_line_ram.sv
// ============================================================================
//  Module      : esp_line_ram
//  Description : Simple dual-port synchronous RAM holding one line of text;
//                one write port, one registered read port.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module esp_line_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Write port: storage array carries no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/esp_at_line_parser.sv
// ============================================================================
//  Module      : esp_at_line_parser
//  Description : Assembles ESP8266 UART response bytes into LF-terminated
//                lines (CR stripped), classifies OK/ERROR/ready/FAIL and holds
//                each line for the command sequencer until acknowledged.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module esp_at_line_parser
    import esp_at_pkg::*;
#(
    parameter int LINE_MAX = 64,
    parameter int AW       = 6
) (
    input  logic          clock25,
    input  logic          reset_n,
    input  logic          rx_ready,
    input  logic [7:0]    rx_byte,
    output logic          line_valid,
    output logic [AW:0]   line_len,
    output logic [2:0]    line_kind,
    output logic          line_trunc,
    input  logic          line_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          prompt,
    output logic          overrun
);

    localparam logic [AW:0] COUNT_MAX = (AW+1)'(LINE_MAX);

    state_e     state;
    state_e     state_next;
    logic [AW:0] count;
    logic        trunc;
    logic [3:0]  match;      // {FAIL, ready, ERROR, OK} still possible
    logic [3:0]  hit;
    logic        store;
    logic        finalize;
    logic        prompt_next;
    logic        drop;
    logic        at_limit;
    logic        wr_en;
    line_kind_e  kind_calc;

    assign at_limit = (count == COUNT_MAX);
    assign wr_en    = store && !at_limit;

    // Does the incoming byte continue each keyword at the current position
    always_comb begin
        hit[0] = kw_hit(KW_OK_STR,    KW_OK_LEN,    int'(count), rx_byte);
        hit[1] = kw_hit(KW_ERROR_STR, KW_ERROR_LEN, int'(count), rx_byte);
        hit[2] = kw_hit(KW_READY_STR, KW_READY_LEN, int'(count), rx_byte);
        hit[3] = kw_hit(KW_FAIL_STR,  KW_FAIL_LEN,  int'(count), rx_byte);
    end

    // Kind of the line being finalized: exact full-length, untruncated match
    always_comb begin
        kind_calc = KIND_OTHER;
        if (!trunc) begin
            if (match[0] && count == (AW+1)'(KW_OK_LEN)) begin
                kind_calc = KIND_OK;
            end else if (match[1] && count == (AW+1)'(KW_ERROR_LEN)) begin
                kind_calc = KIND_ERROR;
            end else if (match[2] && count == (AW+1)'(KW_READY_LEN)) begin
                kind_calc = KIND_READY;
            end else if (match[3] && count == (AW+1)'(KW_FAIL_LEN)) begin
                kind_calc = KIND_FAIL;
            end
        end
    end

    // State register
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-byte actions
    always_comb begin
        state_next  = state;
        store       = 1'b0;
        finalize    = 1'b0;
        prompt_next = 1'b0;
        drop        = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (rx_ready) begin
                    if (rx_byte == CHAR_CR) begin
                        // stripped
                    end else if (rx_byte == CHAR_LF) begin
                        if (count != '0) begin
                            finalize   = 1'b1;
                            state_next = ST_HOLD;
                        end
                    end else if (rx_byte == CHAR_PROMPT && count == '0) begin
                        prompt_next = 1'b1;
                    end else begin
                        store = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                drop = rx_ready;
                if (line_ack) begin
                    state_next = ST_COLLECT;
                end
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // Line assembly, result registers and status flags
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            trunc      <= 1'b0;
            match      <= 4'hF;
            line_valid <= 1'b0;
            line_len   <= '0;
            line_kind  <= 3'd0;
            line_trunc <= 1'b0;
            prompt     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            prompt <= prompt_next;
            if (finalize) begin
                line_valid <= 1'b1;
                line_len   <= count;
                line_kind  <= kind_calc;
                line_trunc <= trunc;
                count      <= '0;
                trunc      <= 1'b0;
                match      <= 4'hF;
            end else if (store) begin
                if (!at_limit) begin
                    count <= count + 1'b1;
                    match <= match & hit;
                end else begin
                    trunc <= 1'b1;
                end
            end
            if (state == ST_HOLD) begin
                if (drop) begin
                    overrun <= 1'b1;
                end else if (line_ack) begin
                    overrun <= 1'b0;
                end
                if (line_ack) begin
                    line_valid <= 1'b0;
                end
            end
        end
    end

    esp_line_ram #(
        .DEPTH (LINE_MAX),
        .AW    (AW)
    ) u_ram (
        .clk   (clock25),
        .rst_n (reset_n),
        .we    (wr_en),
        .waddr (count[AW-1:0]),
        .wdata (rx_byte),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_esp_at_line_parser.sv
// ============================================================================
//  Module      : tb_esp_at_line_parser
//  Description : Self-checking bench for esp_at_line_parser with directed
//                sequences and randomized byte streams against a line-level
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_esp_at_line_parser;

    localparam int LINE_MAX = 64;
    localparam int AW       = 6;

    logic          clock25  = 1'b0;
    logic          reset_n  = 1'b0;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_byte  = 8'h00;
    logic          line_ack = 1'b0;
    logic [AW-1:0] rd_addr  = '0;
    logic          line_valid;
    logic [AW:0]   line_len;
    logic [2:0]    line_kind;
    logic          line_trunc;
    logic [7:0]    rd_data;
    logic          prompt;
    logic          overrun;

    esp_at_line_parser #(.LINE_MAX(LINE_MAX), .AW(AW)) dut (
        .clock25    (clock25),
        .reset_n    (reset_n),
        .rx_ready   (rx_ready),
        .rx_byte    (rx_byte),
        .line_valid (line_valid),
        .line_len   (line_len),
        .line_kind  (line_kind),
        .line_trunc (line_trunc),
        .line_ack   (line_ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .prompt     (prompt),
        .overrun    (overrun)
    );

    always #20 clock25 = ~clock25;

    int total = 0;
    int bad   = 0;

    // Reference model: line text as a queue, outputs as plain values
    bit                m_hold;
    bit                m_valid;
    bit                m_cur_trunc;
    bit                m_trunc;
    bit                m_overrun;
    bit                m_prompt;
    int                m_len;
    int                m_kind;
    int                m_events;
    byte unsigned      m_line[$];
    byte unsigned      mem[LINE_MAX];
    bit                known[LINE_MAX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit same_text(input byte unsigned q[$], input string k);
        if (q.size() != k.len()) return 1'b0;
        foreach (q[i]) begin
            if (q[i] != k[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int classify(input byte unsigned q[$], input bit tr);
        if (tr) return 0;
        if (same_text(q, "OK"))    return 1;
        if (same_text(q, "ERROR")) return 2;
        if (same_text(q, "ready")) return 3;
        if (same_text(q, "FAIL"))  return 4;
        return 0;
    endfunction

    // Apply the byte/ack seen at one clock edge to the model
    task automatic model_edge(input bit rdy, input byte unsigned b, input bit ack);
        m_prompt = 1'b0;
        if (m_hold) begin
            if (rdy) m_overrun = 1'b1;
            else if (ack) m_overrun = 1'b0;
            if (ack) begin
                m_hold  = 1'b0;
                m_valid = 1'b0;
            end
        end else if (rdy) begin
            if (b == 8'h0D) begin
                // stripped
            end else if (b == 8'h0A) begin
                if (m_line.size() > 0) begin
                    m_len       = m_line.size();
                    m_trunc     = m_cur_trunc;
                    m_kind      = classify(m_line, m_cur_trunc);
                    m_line      = {};
                    m_cur_trunc = 1'b0;
                    m_hold      = 1'b1;
                    m_valid     = 1'b1;
                    m_events++;
                end
            end else if (b == 8'h3E && m_line.size() == 0) begin
                m_prompt = 1'b1;
            end else if (m_line.size() < LINE_MAX) begin
                mem[m_line.size()]   = b;
                known[m_line.size()] = 1'b1;
                m_line.push_back(b);
            end else begin
                m_cur_trunc = 1'b1;
            end
        end
    endtask

    // One clock: drive at negedge, check #1 after the rising edge
    task automatic step(input bit rdy, input byte unsigned b, input bit ack, input int addr);
        byte unsigned exp_rd;
        bit           exp_known;
        @(negedge clock25);
        rx_ready  = rdy;
        rx_byte   = b;
        line_ack  = ack;
        rd_addr   = addr[AW-1:0];
        exp_rd    = mem[addr % LINE_MAX];
        exp_known = known[addr % LINE_MAX];
        model_edge(rdy, b, ack);
        @(posedge clock25);
        #1;
        check("line_valid", line_valid, m_valid);
        check("prompt", prompt, m_prompt);
        check("overrun", overrun, m_overrun);
        if (exp_known) check("rd_data", rd_data, exp_rd);
        if (m_valid) begin
            check("line_len", line_len, m_len);
            check("line_kind", line_kind, m_kind);
            check("line_trunc", line_trunc, m_trunc);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0, 0);
        step(1'b0, 8'h00, 1'b0, 0);
    endtask

    // Read back the whole held line, then acknowledge it
    task automatic drain();
        if (m_valid) begin
            for (int i = 0; i < m_len; i++) step(1'b0, 8'h00, 1'b0, i);
            step(1'b0, 8'h00, 1'b1, 0);
        end
        step(1'b0, 8'h00, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clock25);
        #5;
        reset_n  = 1'b0;
        rx_ready = 1'b0;
        line_ack = 1'b0;
        #1;
        check("rst line_valid", line_valid, 0);
        check("rst line_len", line_len, 0);
        check("rst line_kind", line_kind, 0);
        check("rst line_trunc", line_trunc, 0);
        check("rst prompt", prompt, 0);
        check("rst overrun", overrun, 0);
        check("rst rd_data", rd_data, 0);
        m_hold = 0; m_valid = 0; m_cur_trunc = 0; m_trunc = 0;
        m_overrun = 0; m_prompt = 0; m_len = 0; m_kind = 0;
        m_line = {};
        repeat (2) @(negedge clock25);
        reset_n = 1'b1;
    endtask

    byte unsigned pend[$];
    string        kws[8] = '{"OK", "ERROR", "ready", "FAIL", "OKAY", "ERRO", ">", "Ok"};

    task automatic refill();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) begin
            string k;
            k = kws[$urandom_range(0, 7)];
            for (int i = 0; i < k.len(); i++) pend.push_back(k[i]);
            if ($urandom_range(0, 1) == 1) pend.push_back(8'h0D);
            pend.push_back(8'h0A);
        end else begin
            int n;
            n = $urandom_range(0, 80);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) pend.push_back(8'($urandom_range(0, 255)));
                else pend.push_back(8'($urandom_range(8'h41, 8'h5A)));
            end
            pend.push_back(8'h0A);
        end
    endtask

    initial begin
        int ev0;
        foreach (known[i]) known[i] = 1'b0;
        m_events = 0;
        do_reset();
        step(1'b0, 8'h00, 1'b0, 0);

        // Basic OK line and readback
        send_str("OK\r\n");
        check("ok kind", line_kind, 1);
        drain();

        // Blank lines must not surface
        ev0 = m_events;
        send_str("\r\n\r\nERROR\r\n");
        check("error events", m_events - ev0, 1);
        drain();

        send_str("AT+GMR\r\n");
        drain();
        send_str("OKAY\r\n");
        drain();

        // Truncation
        for (int i = 0; i < 70; i++) step(1'b1, 8'h41, 1'b0, 63);
        send_str("\r\n");
        check("trunc len", line_len, 64);
        step(1'b0, 8'h00, 1'b0, 63);
        check("trunc rd63", rd_data, 8'h41);
        drain();

        // Overrun while held
        send_str("ERROR\r\n");
        send_str("ready\r\n");
        check("overrun held", overrun, 1);
        drain();
        send_str("ready\r\n");
        drain();

        // Prompt, then reset mid-line
        send_str(">");
        send_str("ER");
        do_reset();
        step(1'b0, 8'h00, 1'b0, 0);
        send_str("FAIL\r\n");
        check("fail kind", line_kind, 4);
        drain();

        // Randomized traffic
        for (int c = 0; c < 5000; c++) begin
            bit rdy;
            bit ack;
            byte unsigned b;
            if (pend.size() == 0) refill();
            rdy = ($urandom_range(0, 3) != 0);
            b   = rdy ? pend.pop_front() : 8'($urandom_range(0, 255));
            ack = m_valid ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
            step(rdy, b, ack, $urandom_range(0, LINE_MAX - 1));
            if (c == 2500) begin
                do_reset();
                pend = {};
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
